// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it drives requests and consumes in-order responses.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the RV32IM pipeline: owns the PC, issues word fetches, buffers
// in-order responses in a small FIFO and presents {pc, instruction, valid} to ID.
// Redirects flush the buffer and count off stale in-flight responses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_stall_i,
    input  logic                 redirect_en_i,
    input  logic [31:0]          redirect_pc_i,
    fetch_stage_if.master        imem,
    output logic                 if_valid_o,
    output logic [31:0]          if_pc_o,
    output logic [31:0]          if_instruction_o
);
    localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned   PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   LIMIT    = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   buf_pc_q   [FIFO_DEPTH];
    logic [31:0]   buf_data_q [FIFO_DEPTH];

    logic          credit_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   resp_tag_s;
    logic [1:0]    redirect_lsb_unused_s;

    // Buffer pointers wrap at FIFO_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Redirect targets are word aligned; the low bits are dropped.
    assign redirect_lsb_unused_s = redirect_pc_i[1:0];

    // Every issued request must have a buffer slot waiting for it, so the
    // response path never needs backpressure.
    assign credit_s            = (({1'b0, outst_q} + {1'b0, count_q}) < LIMIT);
    assign imem.imem_req_valid = !rst && !redirect_en_i && credit_s;
    assign imem.imem_addr      = pc_q;
    assign req_fire_s          = imem.imem_req_valid && imem.imem_req_ready;

    // A redirect flushes the buffer, so nothing is pushed or popped in that cycle.
    assign if_valid_o = (count_q != '0);
    assign pop_s      = if_valid_o && !id_stall_i && !redirect_en_i;
    assign push_s     = imem.imem_resp_valid && (drop_q == '0) && !redirect_en_i;

    // With no stale responses pending, the outstanding requests were issued
    // back to back ending at pc-4, so the oldest one sits at pc - 4*outstanding.
    assign resp_tag_s = pc_q - 32'({outst_q, 2'b00});

    assign if_pc_o          = if_valid_o ? buf_pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign if_instruction_o = if_valid_o ? buf_data_q[rd_ptr_q] : NOP;

    // Next-state for PC, credit counters and buffer pointers; redirect has priority.
    always_comb begin
        pc_d     = pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_en_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (imem.imem_resp_valid) begin
                outst_d = outst_q - CW'(1);
                drop_d  = outst_q - CW'(1);
            end else begin
                outst_d = outst_q;
                drop_d  = outst_q;
            end
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            case ({req_fire_s, imem.imem_resp_valid})
                2'b10:   outst_d = outst_q + CW'(1);
                2'b01:   outst_d = outst_q - CW'(1);
                default: outst_d = outst_q;
            endcase
            if (imem.imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // PC, counters and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer storage, written with each accepted non-stale response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]   <= 32'h0000_0000;
                buf_data_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            buf_pc_q[wr_ptr_q]   <= resp_tag_s;
            buf_data_q[wr_ptr_q] <= imem.imem_resp_data;
        end else begin
            buf_pc_q   <= buf_pc_q;
            buf_data_q <= buf_data_q;
        end
    end

    fetch_stage_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .outst_i      (outst_q),
        .drop_i       (drop_q),
        .count_i      (count_q),
        .resp_valid_i (imem.imem_resp_valid)
    );
endmodule

// Invariants of the fetch credit scheme.
module fetch_stage_chk #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CW         = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] outst_i,
    input logic [CW-1:0] drop_i,
    input logic [CW-1:0] count_i,
    input logic          resp_valid_i
);
    localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

    a_credit: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, outst_i} + {1'b0, count_i}) <= LIMIT));
    a_drop: assert property (@(posedge clk) disable iff (rst)
        (drop_i <= outst_i));
    a_resp: assert property (@(posedge clk) disable iff (rst)
        !(resp_valid_i && (outst_i == '0)));
endmodule
